// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity selectors and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register (LSB out first) with a bit counter; done marks the last data bit.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_TX,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  shift_en,
  input  logic                  cnt_en,
  output logic                  bit_out,
  output logic                  done
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk_TX) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (load)
        shreg <= data_in;
      else if (shift_en)
        shreg <= shreg >> 1;

      // Counter tracks the bit currently on the line; it clears on the last bit.
      if (load)
        cnt <= '0;
      else if (cnt_en)
        cnt <= done ? '0 : cnt + CW'(1);
    end
  end

  assign bit_out = shreg[0];
  assign done    = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, one stop bit.
// Define UART_TX_HOLD_BUF_EN to add a one-entry holding buffer for back-to-back frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_TX,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_ready
);

  tx_state_e             state, next_state;
  logic                  accept, pending, launch;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_par_en, src_par_typ;
  logic                  par_en_q, par_bit_q;
  logic                  tx_d;
  logic                  bit_out, done;

  assign accept = Data_Valid && tx_ready;
  assign launch = (next_state == START);

`ifdef UART_TX_HOLD_BUF_EN
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_par_en, buf_par_typ;

  assign tx_ready    = !buf_full;
  assign pending     = buf_full || accept;
  assign src_data    = buf_full ? buf_data    : P_DATA;
  assign src_par_en  = buf_full ? buf_par_en  : PAR_EN;
  assign src_par_typ = buf_full ? buf_par_typ : PAR_TYP;

  // A word goes to the buffer unless it is launched straight into the shifter.
  always_ff @(posedge clk_TX) begin
    if (rst) begin
      buf_full    <= 1'b0;
      buf_data    <= '0;
      buf_par_en  <= 1'b0;
      buf_par_typ <= 1'b0;
    end else if (accept && !(launch && !buf_full)) begin
      buf_full    <= 1'b1;
      buf_data    <= P_DATA;
      buf_par_en  <= PAR_EN;
      buf_par_typ <= PAR_TYP;
    end else if (launch) begin
      buf_full    <= 1'b0;
    end
  end
`else
  assign tx_ready    = !busy;
  assign pending     = accept;
  assign src_data    = P_DATA;
  assign src_par_en  = PAR_EN;
  assign src_par_typ = PAR_TYP;
`endif

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk_TX   (clk_TX),
    .rst      (rst),
    .load     (launch),
    .data_in  (src_data),
    .shift_en (next_state == DATA),
    .cnt_en   (state == DATA),
    .bit_out  (bit_out),
    .done     (done)
  );

  always_ff @(posedge clk_TX) begin
    if (rst) begin
      state     <= IDLE;
      TX_OUT    <= STOP_BIT;
      busy      <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state  <= next_state;
      TX_OUT <= tx_d;
      busy   <= (next_state != IDLE);
      if (launch) begin
        par_en_q  <= src_par_en;
        par_bit_q <= (^src_data) ^ (src_par_typ == PAR_ODD);
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (pending) next_state = START;
      START:   next_state = DATA;
      DATA:    if (done) next_state = par_en_q ? PARITY : STOP;
      PARITY:  next_state = STOP;
      STOP:    next_state = pending ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Line level is registered from the state being entered, so it lines up with state.
  always_comb begin
    tx_d = STOP_BIT;
    unique case (next_state)
      IDLE:    tx_d = STOP_BIT;
      START:   tx_d = START_BIT;
      DATA:    tx_d = bit_out;
      PARITY:  tx_d = par_bit_q;
      STOP:    tx_d = STOP_BIT;
      default: tx_d = STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame; expectations follow UART_TX_HOLD_BUF_EN if defined.
module tb_uart_tx_frame;

  logic       clk_TX = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;
  logic       tx_ready;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk_TX = ~clk_TX;

  uart_tx_frame #(
    .DATA_WIDTH(8)
  ) dut (
    .clk_TX     (clk_TX),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .tx_ready   (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called mid-cycle; the following rising edge is the accept edge N.
  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    @(posedge clk_TX);
    #1 Data_Valid = 1'b0;
  endtask

  // exp holds the line levels in time order, first bit in exp[len-1].
  // inj_k > 0 offers 0x3C during frame cycle index inj_k instead of scrambling inputs.
  task automatic check_frame(input string tag, input logic [15:0] exp, input int len,
                             input int inj_k);
    logic exp_rdy;
    for (int k = 0; k < len; k++) begin
      @(negedge clk_TX);
      check($sformatf("%s_tx%0d", tag, k), 32'(TX_OUT), 32'(exp[len-1-k]));
      check($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
`ifdef UART_TX_HOLD_BUF_EN
      exp_rdy = (inj_k == 0 || k <= inj_k) ? 1'b1 : 1'b0;
`else
      exp_rdy = 1'b0;
`endif
      check($sformatf("%s_rdy%0d", tag, k), 32'(tx_ready), 32'(exp_rdy));
      if (inj_k == 0) begin
        P_DATA  = 8'($urandom);
        PAR_EN  = ~PAR_EN;
        PAR_TYP = ~PAR_TYP;
      end else if (k == inj_k) begin
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
      end else if (k == inj_k + 1) begin
        Data_Valid = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_TX);
      check($sformatf("%s_tx%0d", tag, k), 32'(TX_OUT), 32'd1);
      check($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd0);
      check($sformatf("%s_rdy%0d", tag, k), 32'(tx_ready), 32'd1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    Data_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    repeat (2) @(posedge clk_TX);
    check_idle("reset", 1);
    rst = 1'b0;
    check_idle("idle0", 2);

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    send(8'hA5, 1'b1, 1'b0);
    check_frame("a5_even", 16'b0101_0010_101, 11, 0);
    check_idle("a5_idle", 2);

    // 0x00 odd parity: parity bit 1
    send(8'h00, 1'b1, 1'b1);
    check_frame("00_odd", 16'b0000_0000_011, 11, 0);
    check_idle("00_idle", 2);

    // 0xFF no parity: 10-cycle frame
    send(8'hFF, 1'b0, 1'b0);
    check_frame("ff_nopar", 16'b0111_1111_11, 10, 0);
    check_idle("ff_idle", 2);

    // Reset asserted during cycle N+5 drops the frame
    send(8'hA5, 1'b1, 1'b0);
    check_frame("rst_pre", 16'b0101, 4, 0);
    @(posedge clk_TX);
    #1 rst = 1'b1;
    @(posedge clk_TX);
    #1 rst = 1'b0;
    check_idle("rst_post", 3);
    // 0x5A no parity: 0,0,1,0,1,1,0,1,0,1
    send(8'h5A, 1'b0, 1'b0);
    check_frame("rst_clean", 16'b0010_1101_01, 10, 0);
    check_idle("clean_idle", 2);

    // 0x81 frame with 0x3C offered mid-frame
    send(8'h81, 1'b0, 1'b0);
    check_frame("busy_81", 16'b0100_0000_11, 10, 3);
`ifdef UART_TX_HOLD_BUF_EN
    check_frame("buf_3c", 16'b0001_1110_01, 10, 0);
    check_idle("buf_idle", 3);
`else
    check_idle("ignored_3c", 12);
`endif

    // 0x3C odd parity, inputs scrambled in flight: 0,0,0,1,1,1,1,0,0,1,1
    send(8'h3C, 1'b1, 1'b1);
    check_frame("3c_odd", 16'b0001_1110_011, 11, 0);
    check_idle("3c_idle", 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
